// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: bit timer and frame FSM with a registered serial output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int clks_per_bit = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] i_data_byte,
  output logic       tx_done,
  output logic       tx
);

  localparam int                CNT_W    = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(clks_per_bit - 1);

  tx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] data_reg, data_nxt;
  logic                 tx_nxt;
  logic                 done_nxt;
  logic                 bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      data_reg <= '0;
      tx       <= STOP_BIT;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      data_reg <= data_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

  // tx_nxt is the level of the bit that begins on this edge, so tx is a pure register.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_end ? '0 : cnt + CNT_W'(1);
    idx_nxt   = idx;
    data_nxt  = data_reg;
    tx_nxt    = tx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        tx_nxt  = STOP_BIT;
        if (tx_start) begin
          data_nxt  = i_data_byte;
          idx_nxt   = '0;
          tx_nxt    = START_BIT;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_nxt   = '0;
          tx_nxt    = data_reg[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == 3'(DATA_BITS - 1)) begin
            tx_nxt    = STOP_BIT;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
            tx_nxt  = data_reg[idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_nxt    = STOP_BIT;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        tx_nxt    = STOP_BIT;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized and directed bench for uart_transmitter against a cycle-count frame model.
module tb_uart_transmitter;

  localparam int CPB     = 4;
  localparam int CPB_DEF = 868;
  localparam int FRAME   = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] data;
  logic       tx_done;
  logic       tx;

  logic       start_d;
  logic [7:0] data_d;
  logic       done_d;
  logic       tx_d;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: a frame is just "edges elapsed since acceptance".
  bit         m_busy = 1'b0;
  int         m_e    = 0;
  logic [7:0] m_byte = 8'h00;
  int         done_cycles[$];

  always #5 clk = ~clk;

  uart_transmitter #(.clks_per_bit(CPB)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .i_data_byte(data),
    .tx_done(tx_done), .tx(tx)
  );

  uart_transmitter dut_def (
    .clk(clk), .reset(reset), .tx_start(start_d), .i_data_byte(data_d),
    .tx_done(done_d), .tx(tx_d)
  );

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    if (m_busy && m_e < FRAME) return frame_bit(m_byte, m_e / CPB);
    return 1'b1;
  endfunction

  function automatic logic exp_done();
    return (m_busy && m_e == FRAME);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge: check outputs, drive inputs, advance one clock, update model.
  task automatic step(input logic st, input logic [7:0] d);
    check("tx", tx, exp_tx());
    check("tx_done", tx_done, exp_done());
    if (tx_done === 1'b1) done_cycles.push_back(cyc);
    tx_start = st;
    data     = d;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_busy = 1'b0;
    end else if (!m_busy || m_e == FRAME) begin
      if (st) begin
        m_busy = 1'b1;
        m_e    = 0;
        m_byte = d;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_e++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    m_busy = 1'b0;
    check("rst_tx", tx, 1'b1);
    check("rst_done", tx_done, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h3C);
    reset = 1'b1;
  endtask

  initial begin
    int acc;
    int pulses;
    int first_e;
    reset    = 1'b0;
    tx_start = 1'b0;
    data     = 8'h00;
    start_d  = 1'b0;
    data_d   = 8'h00;
    @(negedge clk);

    // Reset held, then released with tx_start low: line stays idle.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00);

    // Single 0x75 frame: completion 40 cycles after acceptance.
    done_cycles.delete();
    step(1'b1, 8'h75);
    acc = cyc;
    for (int i = 0; i < 50; i++) step(1'b0, 8'h75);
    check_int("single_pulses", done_cycles.size(), 1);
    if (done_cycles.size() > 0) check_int("single_latency", done_cycles[0] - acc, FRAME);

    // tx_start held: back-to-back frames with a 41-cycle period.
    done_cycles.delete();
    for (int i = 0; i < 3 * (FRAME + 1) + 5; i++) step(1'b1, 8'h75);
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 8'h75);
    check_int("held_pulses", done_cycles.size(), 4);
    for (int i = 1; i < done_cycles.size(); i++)
      check_int("held_period", done_cycles[i] - done_cycles[i-1], FRAME + 1);

    // Data changes and ignored start requests mid-frame.
    step(1'b1, 8'h75);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h75);
    for (int i = 0; i < 24; i++) step(i % 3 == 0, 8'hFF);
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 8'h00);

    // Reset during the data phase aborts without a completion pulse.
    done_cycles.delete();
    step(1'b1, 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom));
    apply_reset();
    step(1'b1, 8'hA5);
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 8'($urandom));
    check_int("post_reset_pulses", done_cycles.size(), 1);

    // Random traffic: sporadic start requests with random bytes.
    for (int i = 0; i < 800; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 8'h00);

    // Default bit time: 868 cycles per bit, completion 8680 cycles after acceptance.
    start_d = 1'b1;
    data_d  = 8'h75;
    @(negedge clk);
    start_d = 1'b0;
    pulses  = 0;
    first_e = -1;
    for (int e = 0; e < 10 * CPB_DEF + 10; e++) begin
      if (e % CPB_DEF == CPB_DEF / 2 && e < 10 * CPB_DEF)
        check("def_tx", tx_d, frame_bit(8'h75, e / CPB_DEF));
      if (done_d === 1'b1) begin
        pulses++;
        if (first_e < 0) first_e = e;
      end
      @(negedge clk);
    end
    check_int("def_pulses", pulses, 1);
    check_int("def_latency", first_e, 10 * CPB_DEF);
    check("def_idle_tx", tx_d, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter clks_per_bit, default 868, giving clock cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port tx_start, input, 1 bit: level request to send a frame, sampled only in IDLE.
REQ-005 SHALL have port i_data_byte, input, 8 bits: byte to send, captured when a frame is accepted.
REQ-006 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame completion.
REQ-007 SHALL have port tx, output, 1 bit: serial line, idle high, driven directly from a register.

Function
REQ-008 SHALL implement an FSM with states IDLE, START, DATA and STOP.
REQ-009 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts exactly clks_per_bit cycles.
REQ-010 IDLE SHALL drive tx=1; on any clock edge with tx_start=1 it SHALL latch i_data_byte into an internal shift/data register, clear the bit counter and bit index, and enter START.
REQ-011 tx SHALL go low on the clock edge that accepts tx_start (registered output, so visible the cycle after tx_start is sampled high).
REQ-012 START SHALL hold tx=0 for clks_per_bit cycles, then enter DATA with bit index 0.
REQ-013 DATA SHALL drive tx=latched_byte[index] for clks_per_bit cycles per bit; after index 7 completes it SHALL enter STOP.
REQ-014 STOP SHALL hold tx=1 for clks_per_bit cycles; on the edge ending the stop bit it SHALL enter IDLE and set tx_done=1 for exactly one cycle.
REQ-015 The cycle counter SHALL count 0..clks_per_bit-1, have width $clog2(clks_per_bit), and wrap to 0 at every bit boundary.
REQ-016 tx_start and i_data_byte SHALL be ignored outside IDLE; changes to i_data_byte mid-frame SHALL NOT affect the frame in progress.
REQ-017 If tx_start is held high continuously, frames SHALL repeat back-to-back with exactly one IDLE cycle (tx=1) between them, giving a frame period of 10*clks_per_bit+1 cycles.
REQ-018 tx_done SHALL be 0 in every cycle other than the single completion pulse.

Reset
REQ-019 Reset low SHALL immediately force: state=IDLE, tx=1, tx_done=0, counter=0, bit index=0, data register=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse; after release the block SHALL be in IDLE and accept tx_start on the first clock edge.

Structure
REQ-021 A shared package uart_pkg SHALL hold the FSM state enum typedef and frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1).
REQ-022 No sub-module is required; the bit timer and FSM SHALL reside in uart_transmitter.

Verification (simulate with clks_per_bit=4 unless stated)
REQ-023 Reset low, then released with tx_start=0 -> tx=1 and tx_done=0 indefinitely.
REQ-024 i_data_byte=0x75, tx_start pulsed for 1 cycle -> tx emits bits 0,1,0,1,0,1,1,1,0,1, each 4 cycles wide; tx_done is high for one cycle 40 cycles after acceptance; tx then stays 1.
REQ-025 tx_start held high with i_data_byte=0x75 -> consecutive identical frames with a period of 41 cycles; one tx_done pulse per frame.
REQ-026 i_data_byte changed to 0xFF mid-frame -> current frame still carries 0x75, and the next accepted frame carries 0xFF.
REQ-027 Reset asserted during DATA -> tx=1 and tx_done=0 immediately; no completion pulse; a fresh frame after release is correct.
REQ-028 Default clks_per_bit=868 at 100 MHz with 0x75 -> each bit is 8.68 us and tx_done occurs 86.8 us after start.
